// File: rtl/pirdsp_alu_pkg.sv
// rtl/pirdsp_alu_pkg.sv - shared SIMD ALU lane definitions and segment maps
package pirdsp_alu_pkg;

  localparam int P_W   = 45;
  localparam int SEG_N = 4;

  // Segment widths and LSB offsets of the four carry segments
  localparam int SEG0_W   = 17;
  localparam int SEG1_W   = 10;
  localparam int SEG2_W   = 8;
  localparam int SEG3_W   = 10;
  localparam int SEG0_LSB = 0;
  localparam int SEG1_LSB = 17;
  localparam int SEG2_LSB = 27;
  localparam int SEG3_LSB = 35;

  typedef enum logic [1:0] {
    mode_27x18   = 2'b00,
    mode_sum_9x9 = 2'b01,
    mode_sum_4x4 = 2'b10,
    mode_rsvd    = 2'b11
  } simd_mode_e;

  // Segments that terminate a lane in each mode; only those forward a carry
  localparam logic [SEG_N-1:0] TOP_MASK_27X18   = 4'b1000;
  localparam logic [SEG_N-1:0] TOP_MASK_SUM_9X9 = 4'b1010;
  localparam logic [SEG_N-1:0] TOP_MASK_SUM_4X4 = 4'b1111;

  function automatic logic [SEG_N-1:0] top_seg_mask(input simd_mode_e mode);
    logic [SEG_N-1:0] m;
    case (mode)
      mode_sum_9x9: m = TOP_MASK_SUM_9X9;
      mode_sum_4x4: m = TOP_MASK_SUM_4X4;
      default:      m = TOP_MASK_27X18;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pattern_detect_pipe.sv
// rtl/pattern_detect_pipe.sv - pattern compare, one-cycle flag delay, overflow/underflow
module pattern_detect_pipe
  import pirdsp_alu_pkg::*;
#(
  parameter logic [P_W-1:0] PATTERN = '0,
  parameter logic [P_W-1:0] MASK    = {P_W{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic           clr,
  input  logic [P_W-1:0] p,
  output logic           pattern_detect,
  output logic           pattern_b_detect,
  output logic           overflow,
  output logic           underflow
);

  logic pd_q, pd_d;
  logic pbd_q, pbd_d;
  logic pd_dly_q, pd_dly_d;
  logic pbd_dly_q, pbd_dly_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic match, match_b;
  assign match   = ((p ^ PATTERN)  & ~MASK) == '0;
  assign match_b = ((p ^ ~PATTERN) & ~MASK) == '0;

  // Flag pipeline: compare P, then judge over/underflow against the previous flags
  always_comb begin
    pd_d      = pd_q;
    pbd_d     = pbd_q;
    pd_dly_d  = pd_dly_q;
    pbd_dly_d = pbd_dly_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (clr) begin
      pd_d      = 1'b0;
      pbd_d     = 1'b0;
      pd_dly_d  = 1'b0;
      pbd_dly_d = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else if (ce) begin
      pd_d      = match;
      pbd_d     = match_b;
      pd_dly_d  = pd_q;
      pbd_dly_d = pbd_q;
      ovf_d     = pd_dly_q  & ~pd_q & ~pbd_q;
      unf_d     = pbd_dly_q & ~pd_q & ~pbd_q;
    end
  end

  // Flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pd_q      <= 1'b0;
      pbd_q     <= 1'b0;
      pd_dly_q  <= 1'b0;
      pbd_dly_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pd_q      <= pd_d;
      pbd_q     <= pbd_d;
      pd_dly_q  <= pd_dly_d;
      pbd_dly_q <= pbd_dly_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign pattern_detect   = pd_q;
  assign pattern_b_detect = pbd_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;

endmodule

// File: rtl/p_register_simd_accumulator.sv
// rtl/p_register_simd_accumulator.sv - P register, lane carries, feedback and frame counter
module p_register_simd_accumulator
  import pirdsp_alu_pkg::*;
#(
  parameter int              ACC_LEN = 16,
  parameter logic [P_W-1:0]  PATTERN = 45'h0,
  parameter logic [P_W-1:0]  MASK    = 45'h1FFF_FFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CE,
  input  logic             CLR,
  input  logic [1:0]       USE_SIMD,
  input  logic             ZSEL,
  input  logic             in_valid,
  input  logic [P_W-1:0]   S,
  input  logic [7:0]       result_SIDM_carry_in,
  output logic [P_W-1:0]   P,
  output logic             P_valid,
  output logic [SEG_N-1:0] CARRYOUT,
  output logic [P_W-1:0]   W_fb,
  output logic [P_W-1:0]   Z_fb,
  output logic             PATTERNDETECT,
  output logic             PATTERNBDETECT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [9:0]       acc_count,
  output logic             acc_done
);

  localparam logic [9:0] ACC_LAST = 10'(ACC_LEN - 1);

  logic [P_W-1:0]   p_q, p_d;
  logic [SEG_N-1:0] carry_q, carry_d;
  logic             p_valid_q, p_valid_d;
  logic [9:0]       acc_count_q, acc_count_d;
  logic             acc_done_q, acc_done_d;

  logic             capture;
  logic [SEG_N-1:0] zwxy_carry;
  logic             unused_wxy_carry;

  assign capture = CE & in_valid & ~CLR;

  // Only the Z+W+X+Y chain carry leaves the stage; the W+X+Y chain is not forwarded
  assign zwxy_carry = {result_SIDM_carry_in[7], result_SIDM_carry_in[5],
                       result_SIDM_carry_in[3], result_SIDM_carry_in[1]};
  assign unused_wxy_carry = ^{result_SIDM_carry_in[6], result_SIDM_carry_in[4],
                              result_SIDM_carry_in[2], result_SIDM_carry_in[0]};

  // Capture S, mask carries by lane layout, advance the frame counter
  always_comb begin
    p_d         = p_q;
    carry_d     = carry_q;
    p_valid_d   = 1'b0;
    acc_count_d = acc_count_q;
    acc_done_d  = 1'b0;
    if (CLR) begin
      p_d         = '0;
      carry_d     = '0;
      acc_count_d = '0;
    end else if (capture) begin
      p_d       = S;
      carry_d   = zwxy_carry & top_seg_mask(simd_mode_e'(USE_SIMD));
      p_valid_d = 1'b1;
      if (acc_count_q == ACC_LAST) begin
        acc_count_d = '0;
        acc_done_d  = 1'b1;
      end else begin
        acc_count_d = acc_count_q + 10'd1;
      end
    end
  end

  // P register and frame state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      carry_q     <= '0;
      p_valid_q   <= 1'b0;
      acc_count_q <= '0;
      acc_done_q  <= 1'b0;
    end else begin
      p_q         <= p_d;
      carry_q     <= carry_d;
      p_valid_q   <= p_valid_d;
      acc_count_q <= acc_count_d;
      acc_done_q  <= acc_done_d;
    end
  end

  pattern_detect_pipe #(
    .PATTERN (PATTERN),
    .MASK    (MASK)
  ) u_pattern_detect_pipe (
    .clk              (clk),
    .reset            (reset),
    .ce               (CE),
    .clr              (CLR),
    .p                (p_q),
    .pattern_detect   (PATTERNDETECT),
    .pattern_b_detect (PATTERNBDETECT),
    .overflow         (OVERFLOW),
    .underflow        (UNDERFLOW)
  );

  assign P         = p_q;
  assign P_valid   = p_valid_q;
  assign CARRYOUT  = carry_q;
  assign acc_count = acc_count_q;
  assign acc_done  = acc_done_q;
  assign W_fb      = p_q;
  // Z shift aligns the upper lane down by the first segment width
  assign Z_fb      = ZSEL ? {{SEG1_LSB{p_q[P_W-1]}}, p_q[P_W-1:SEG1_LSB]} : p_q;

endmodule

// File: doc/p_register_simd_accumulator.md
# p_register_simd_accumulator

Output-side register stage for the 45-bit SIMD ALU. It captures the ALU sum `S` and the per-segment carry pairs into the P register. It feeds `P` back as the W/Z accumulate operands and runs pattern detect with overflow/underflow. It also counts accepted results to frame fixed-length accumulations. It sits directly after the ALU in the DSP datapath and is the consumer end of the ALU's `S`/carry interface.

## Interface
Parameters:
- `ACC_LEN`, default 16: accepted samples per accumulation frame; legal range 1..1023.
- `PATTERN`, default 45'h0: pattern-detect compare value.
- `MASK`, default 45'h1FFF_FFFF_FFFF: 1 = bit ignored in the compare.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous active-high reset.
- `CE` in 1: stage enable.
- `CLR` in 1: synchronous clear of P, flags and counter.
- `USE_SIMD` in 2: lane mode; 00 = 45-bit, 01 = 2×{[26:0],[44:27]}, 10 = 4×{[16:0],[26:17],[34:27],[44:35]}, 11 = treated as 00.
- `ZSEL` in 1: Z feedback select; 0 = P, 1 = P>>>17 (arithmetic).
- `in_valid` in 1: `S` and carries are valid this cycle.
- `S` in 45: ALU sum.
- `result_SIDM_carry_in` in 8: ALU carry pairs; for segment k, bit 2k is the W+X+Y chain carry and bit 2k+1 is the Z+W+X+Y chain carry.
- `P` out 45: registered result.
- `P_valid` out 1: P holds a freshly captured result.
- `CARRYOUT` out 4: per-segment lane carry.
- `W_fb` out 45: W accumulate operand.
- `Z_fb` out 45: Z accumulate operand.
- `PATTERNDETECT` out 1: pattern-detect flag.
- `PATTERNBDETECT` out 1: inverted-pattern detect flag.
- `OVERFLOW` out 1: overflow flag.
- `UNDERFLOW` out 1: underflow flag.
- `acc_count` out 10: accepted samples in the current frame.
- `acc_done` out 1: frame-complete pulse.

## Operation
- **Capture.** When `CE & in_valid & !CLR`:
  - P ← S.
  - Lane carries are computed per the rule below.
  - acc_count increments.
- **Lane carries.**
  - For each segment k: `CARRYOUT[k]` ← `result_SIDM_carry_in[2k+1]` if k is the top segment of a lane in the current `USE_SIMD`, else 0.
  - Top segments by mode: mode 00/11 → {3}; mode 01 → {1,3}; mode 10 → {0,1,2,3}.
- **Feedback.**
  - `W_fb = P` (combinational).
  - `Z_fb = ZSEL ? {{17{P[44]}},P[44:17]} : P` (combinational).
- **Pattern detect.**
  - `PATTERNDETECT` = ((P ^ PATTERN) & ~MASK) == 0.
  - `PATTERNBDETECT` = ((P ^ ~PATTERN) & ~MASK) == 0.
  - Both are evaluated on the full 45-bit P in every SIMD mode.
- **Overflow/underflow.**
  - Both are computed from the previous-cycle `PATTERNDETECT`/`PATTERNBDETECT` (pd_d, pbd_d).
  - `OVERFLOW` = pd_d & !PATTERNDETECT & !PATTERNBDETECT.
  - `UNDERFLOW` = pbd_d & !PATTERNDETECT & !PATTERNBDETECT.
- **Frame counter.**
  - On the capture that brings acc_count to ACC_LEN: acc_count wraps to 0 and `acc_done` pulses for exactly 1 cycle.
- **CLR** (synchronous, any CE):
  - P, CARRYOUT and acc_count are zeroed.
  - `P_valid`, `acc_done`, pd_d and pbd_d are cleared.
  - The sample presented in the same cycle is dropped.
- **CE=0.** Everything holds. `P_valid` and `acc_done` are forced to 0.
- **USE_SIMD changes** take effect on the next capture only; P is not re-split.

## Timing
- **Reset.** All registers are 0 on reset assertion, asynchronously: P, CARRYOUT, P_valid, flags, pd_d, pbd_d, acc_count, acc_done. Reset mid-frame discards the frame.
- **Result path.** S → P: 1 cycle. `P_valid` rises with P and lasts 1 cycle per capture.
- **Flag path.**
  - `PATTERNDETECT`/`PATTERNBDETECT` are registered 1 cycle after P (2 cycles after S).
  - `OVERFLOW`/`UNDERFLOW` are registered 1 cycle after the pattern flags (3 cycles after S).
  - The flag pipeline advances only when CE=1; it keeps advancing during `in_valid`=0 cycles.
- **Frame path.** `acc_done` is coincident with the `P_valid` of the ACC_LEN-th sample.
- **Back-to-back captures** are supported every cycle; there is no backpressure.

## Structure
- Shared package `pirdsp_alu_pkg`:
  - USE_SIMD mode constants (`mode_27x18`, `mode_sum_9x9`, `mode_sum_4x4`).
  - Segment boundaries: 17/10/8/10 widths and LSB offsets 0/17/27/35.
  - The per-mode top-segment masks.
- One sub-module, `pattern_detect_pipe`: PATTERN/MASK compare, the pd_d/pbd_d delay and overflow/underflow logic.
- Counter, capture and feedback stay in the top level.

## Test plan
- **Basic capture and feedback.** Reset, then ZSEL=1, CE=1, S=45'h1_0000_0000 for 1 cycle.
  - Next cycle: P=45'h1_0000_0000, P_valid=1.
  - Z_fb=45'h8000, W_fb=P.
- **SIMD carries.** USE_SIMD=10, result_SIDM_carry_in=8'b10_10_10_10 → CARRYOUT=4'b1111. Same input with USE_SIMD=01 → 4'b1010; with USE_SIMD=00 → 4'b1000.
- **Frame counter.** ACC_LEN=4, in_valid toggling 1/0 over 8 cycles → acc_done pulses once, on the 4th capture; acc_count then returns to 0.
- **Overflow.** PATTERN=0, MASK=45'h0_0000_FFFF (compare on the upper 29 bits).
  - Capture P=45'h0_0000_0005, then P=45'h0_0001_0000.
  - PATTERNDETECT goes 1 then 0; OVERFLOW=1 one cycle later; UNDERFLOW=0.
- **CLR with in_valid.** CLR=1 together with in_valid=1 and S=45'h123 → P=0, P_valid=0, acc_count=0; the sample is dropped.
- **Mid-frame reset and CE=0.**
  - Assert reset asynchronously mid-frame (acc_count=2): all outputs are 0 immediately, before the next clk edge.
  - With CE=0 and in_valid=1, P holds its value.
